// File: rtl/osiris_pkg.sv
// Shared definitions for the writeback stage: result-select encodings.
package osiris_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_PCT = 2'b11
  } result_src_e;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select: picks ALU result, load data, link address or PC target.
module wb_result_mux
  import osiris_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  input  logic [DATA_WIDTH-1:0] i_pc_plus4,
  input  logic [DATA_WIDTH-1:0] i_pc_target,
  input  logic [1:0]            i_result_src,
  output logic [DATA_WIDTH-1:0] o_result
);

  // Pure combinational decode of the result source; stays live during reset.
  always_comb begin
    o_result = i_alu_result;
    case (result_src_e'(i_result_src))
      RES_ALU: o_result = i_alu_result;
      RES_MEM: o_result = i_read_data;
      RES_PC4: o_result = i_pc_plus4;
      RES_PCT: o_result = i_pc_target;
      default: o_result = i_alu_result;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Register file with writeback result mux, write-through bypass and a
// committed-write counter. Index 0 is hardwired to zero and has no storage.
module wb_regfile
  import osiris_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_alu_result_WB,
  input  logic [DATA_WIDTH-1:0] i_read_data_WB,
  input  logic [DATA_WIDTH-1:0] i_pc_plus4_WB,
  input  logic [DATA_WIDTH-1:0] i_pc_target_WB,
  input  logic [REG_WIDTH-1:0]  i_rd_WB,
  input  logic                  i_reg_write_WB,
  input  logic [1:0]            i_result_src_WB,
  input  logic [REG_WIDTH-1:0]  i_rs1_D,
  input  logic [REG_WIDTH-1:0]  i_rs2_D,
  output logic [DATA_WIDTH-1:0] o_rd1_D,
  output logic [DATA_WIDTH-1:0] o_rd2_D,
  output logic [DATA_WIDTH-1:0] o_result_WB,
  output logic [31:0]           o_wb_count
);

  localparam int NREG = 2 ** REG_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [1:NREG-1];
  logic [31:0]           wb_count_q;
  logic                  commit;

  wb_result_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_result_mux (
    .i_alu_result (i_alu_result_WB),
    .i_read_data  (i_read_data_WB),
    .i_pc_plus4   (i_pc_plus4_WB),
    .i_pc_target  (i_pc_target_WB),
    .i_result_src (i_result_src_WB),
    .o_result     (o_result_WB)
  );

  // A write commits only out of reset, when enabled, and never to index 0.
  always_comb begin
    commit = rst_n && i_reg_write_WB && (i_rd_WB != '0);
  end

  // Storage and counter; reset clears everything and swallows any pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      if (commit) begin
        regs_q[i_rd_WB] <= o_result_WB;
      end
      // Counter wraps naturally at 32 bits.
      wb_count_q <= wb_count_q + {31'b0, commit};
    end
  end

  // Read ports: zero for index 0, bypass the in-flight write, else stored value.
  always_comb begin
    o_rd1_D = '0;
    o_rd2_D = '0;
    if (i_rs1_D != '0) begin
      o_rd1_D = (commit && (i_rs1_D == i_rd_WB)) ? o_result_WB : regs_q[i_rs1_D];
    end
    if (i_rs2_D != '0) begin
      o_rd2_D = (commit && (i_rs2_D == i_rd_WB)) ? o_result_WB : regs_q[i_rs2_D];
    end
  end

  assign o_wb_count = wb_count_q;

endmodule
